// File: rtl/ethernet_tx_packet_streamer.sv
// ethernet_tx_packet_streamer: MMIO-filled frame buffer streamed to the MAC as AXI-Stream beats
//   clk_i, reset_i          : logic clock, synchronous active-high reset
//   packet_send_i           : pulse to transmit the buffered frame
//   packet_req_o            : high while idle (writes, size updates and send accepted)
//   packet_wsize_valid_i/_i : frame length in bytes
//   packet_wvalid_i/waddr/wdata/wdata_size : aligned 1/2/4/8-byte buffer writes
//   tx_axis_*               : AXI-Stream master toward the MAC (tuser tied low)
//   send_count_o            : completed frames, wraps at 2^16
module ethernet_tx_packet_streamer #(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p = 2048,
   localparam int b_lp = data_width_p / 8,
   localparam int size_width_lp = $clog2(eth_mtu_p + 1),
   localparam int addr_width_lp = $clog2(eth_mtu_p),
   localparam int wsize_width_lp = ($clog2(b_lp) == 0) ? 1 : $clog2($clog2(b_lp) + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      packet_send_i,
   output logic                      packet_req_o,
   input  logic                      packet_wsize_valid_i,
   input  logic [size_width_lp-1:0]  packet_wsize_i,
   input  logic                      packet_wvalid_i,
   input  logic [addr_width_lp-1:0]  packet_waddr_i,
   input  logic [data_width_p-1:0]   packet_wdata_i,
   input  logic [wsize_width_lp-1:0] packet_wdata_size_i,
   output logic [data_width_p-1:0]   tx_axis_tdata_o,
   output logic [b_lp-1:0]           tx_axis_tkeep_o,
   output logic                      tx_axis_tvalid_o,
   output logic                      tx_axis_tlast_o,
   input  logic                      tx_axis_tready_i,
   output logic                      tx_axis_tuser_o,
   output logic [15:0]               send_count_o
);
   localparam int lg_b_lp = $clog2(b_lp);
   localparam int words_lp = eth_mtu_p / b_lp;
   localparam int widx_lp = addr_width_lp - lg_b_lp;
   localparam int beat_w_lp = size_width_lp - lg_b_lp;

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
   state_t r_state, w_next;

   logic [data_width_p-1:0]  r_mem [words_lp];
   logic [data_width_p-1:0]  r_pdata, r_tdata, w_wdata_sh;
   logic [size_width_lp-1:0] r_size, r_len;
   logic [beat_w_lp-1:0]     r_rd_idx, r_ld_cnt, w_beats;
   logic [b_lp-1:0]          r_tkeep, w_last_keep, w_nmask, w_be;
   logic [lg_b_lp-1:0]       w_lane, w_rem;
   logic [3:0]               w_nbytes;
   logic [15:0]              r_count;
   logic r_pvalid, r_tvalid, r_tlast;
   logic w_idle, w_accept, w_bad_wr, w_wen, w_pop, w_move, w_rd, w_done, w_is_last;

   assign w_idle = (r_state == IDLE);
   assign w_accept = w_idle & packet_send_i & (r_size != '0) & (32'(r_size) <= eth_mtu_p);
   assign w_nbytes = 4'(1) << packet_wdata_size_i;
   assign w_bad_wr = (32'(packet_wdata_size_i) > lg_b_lp) |
                     ((32'(packet_waddr_i) & (32'(w_nbytes) - 32'd1)) != 32'd0);
   assign w_wen = w_idle & packet_wvalid_i & ~w_bad_wr;
   assign w_lane = packet_waddr_i[lg_b_lp-1:0];
   assign w_nmask = ~({b_lp{1'b1}} << w_nbytes);
   assign w_be = w_nmask << w_lane;
   assign w_wdata_sh = packet_wdata_i << {w_lane, 3'b000};

   // frame geometry of the frame in flight, taken from the length captured at send
   assign w_beats = beat_w_lp'((r_len + size_width_lp'(b_lp - 1)) >> lg_b_lp);
   assign w_rem = r_len[lg_b_lp-1:0];
   assign w_last_keep = (w_rem == '0) ? '1 : ~({b_lp{1'b1}} << w_rem);
   assign w_is_last = (r_ld_cnt == w_beats - beat_w_lp'(1));

   // two-entry read-ahead: r_pdata is the RAM output register, r_tdata the AXIS output
   assign w_pop = r_tvalid & tx_axis_tready_i;
   assign w_done = w_pop & r_tlast;
   assign w_move = ~w_idle & r_pvalid & (~r_tvalid | w_pop);
   assign w_rd = ~w_idle & (r_rd_idx < w_beats) & (~r_pvalid | w_move);

   always_ff @(posedge clk_i)
      r_state <= reset_i ? IDLE : w_next;

   always_comb
      w_next = w_idle ? (w_accept ? FILL : IDLE) : (r_state == FILL) ? STREAM : (w_done ? IDLE : STREAM);

   always_comb begin
      packet_req_o = w_idle;
      tx_axis_tdata_o = r_tdata;
      tx_axis_tkeep_o = r_tkeep;
      tx_axis_tvalid_o = r_tvalid;
      tx_axis_tlast_o = r_tlast;
      tx_axis_tuser_o = 1'b0;
      send_count_o = r_count;
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < b_lp; i++)
         if (w_wen & w_be[i]) r_mem[packet_waddr_i[addr_width_lp-1:lg_b_lp]][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
      if (w_rd) r_pdata <= r_mem[r_rd_idx[widx_lp-1:0]];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_size <= '0;
         r_len <= '0;
         r_rd_idx <= '0;
         r_ld_cnt <= '0;
         r_pvalid <= 1'b0;
         r_tvalid <= 1'b0;
         r_tdata <= '0;
         r_tkeep <= '0;
         r_tlast <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_idle & packet_wsize_valid_i) r_size <= packet_wsize_i;
         if (w_accept) begin
            r_len <= r_size;
            r_rd_idx <= '0;
            r_ld_cnt <= '0;
            r_pvalid <= 1'b0;
         end else begin
            if (w_rd) r_rd_idx <= r_rd_idx + beat_w_lp'(1);
            r_pvalid <= w_rd | (r_pvalid & ~w_move);
         end
         if (w_move) begin
            r_tvalid <= 1'b1;
            r_tdata <= r_pdata;
            r_tlast <= w_is_last;
            r_tkeep <= w_is_last ? w_last_keep : '1;
            r_ld_cnt <= r_ld_cnt + beat_w_lp'(1);
         end else if (w_pop) begin
            r_tvalid <= 1'b0;
            r_tlast <= 1'b0;
         end
         if (w_done) r_count <= r_count + 16'd1;
      end
   end

   always_ff @(posedge clk_i)
      if (!reset_i && w_idle && packet_wvalid_i)
         assert (!w_bad_wr) else $error("misaligned or oversized buffer write at 0x%0h", packet_waddr_i);
endmodule

// File: tb/tb_ethernet_tx_packet_streamer.sv
// tb_ethernet_tx_packet_streamer: randomized frames checked against a byte-array model of the buffer
module tb_ethernet_tx_packet_streamer;
   localparam int MTU = 2048;
   localparam int BB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic send = 1'b0;
   logic req;
   logic wsize_valid = 1'b0;
   logic [11:0] wsize = '0;
   logic wvalid = 1'b0;
   logic [10:0] waddr = '0;
   logic [31:0] wdata = '0;
   logic [1:0] wsize_l = '0;
   logic [31:0] tdata;
   logic [3:0] tkeep;
   logic tvalid, tlast, tuser;
   logic tready = 1'b0;
   logic [15:0] send_count;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;
   logic [7:0] mdl [MTU];

   ethernet_tx_packet_streamer #(.data_width_p(32), .eth_mtu_p(MTU)) dut (
      .clk_i(clk), .reset_i(rst),
      .packet_send_i(send), .packet_req_o(req),
      .packet_wsize_valid_i(wsize_valid), .packet_wsize_i(wsize),
      .packet_wvalid_i(wvalid), .packet_waddr_i(waddr),
      .packet_wdata_i(wdata), .packet_wdata_size_i(wsize_l),
      .tx_axis_tdata_o(tdata), .tx_axis_tkeep_o(tkeep), .tx_axis_tvalid_o(tvalid),
      .tx_axis_tlast_o(tlast), .tx_axis_tready_i(tready), .tx_axis_tuser_o(tuser),
      .send_count_o(send_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d, input int sl);
      wvalid = 1'b1;
      waddr = 11'(a);
      wdata = d;
      wsize_l = 2'(sl);
      step;
      wvalid = 1'b0;
      for (int i = 0; i < (1 << sl); i++) mdl[a + i] = d[8*i +: 8];
   endtask

   task automatic set_size(input int n);
      wsize_valid = 1'b1;
      wsize = 12'(n);
      step;
      wsize_valid = 1'b0;
   endtask

   // sends the frame and drains it; expected beats come from mdl and sz alone
   task automatic run_frame(input int sz, input int pct, input bit noise);
      int nb, k, cyc, lat;
      bit done, pstall;
      logic [31:0] pd, exp_d, msk;
      logic [3:0] pk, exp_k;
      logic pl;
      nb = (sz + BB - 1) / BB;
      send = 1'b1;
      step;
      send = 1'b0;
      wvalid = 1'b0;
      wsize_valid = 1'b0;
      lat = 0;
      while (!tvalid && lat < 10) begin
         step;
         lat++;
      end
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL first_tvalid_latency size=%0d: got %0d cycles, want 2", sz, lat);
      end
      if (!tvalid) return;
      k = 0;
      cyc = 0;
      done = 1'b0;
      pstall = 1'b0;
      while (!done && cyc < 4 * nb + 50) begin
         if (pstall) begin
            checks++;
            if (tdata !== pd || tkeep !== pk || tlast !== pl) begin
               errors++;
               $display("FAIL stall_stable beat=%0d: got %h/%h/%b, want %h/%h/%b", k, tdata, tkeep, tlast, pd, pk, pl);
            end
         end
         tready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
         if (noise) begin
            send = 1'($urandom_range(1));
            wvalid = 1'b1;
            waddr = 11'($urandom_range(MTU / 4 - 1) * 4);
            wdata = $urandom;
            wsize_l = 2'd2;
            wsize_valid = 1'b1;
            wsize = 12'($urandom_range(4095));
         end
         if (pct >= 100) begin
            checks++;
            if (tvalid !== 1'b1) begin
               errors++;
               $display("FAIL no_bubble beat=%0d: tvalid got %b, want 1", k, tvalid);
            end
         end
         if (tvalid && tready) begin
            exp_k = (k == nb - 1) ? 4'((1 << (sz - (nb - 1) * BB)) - 1) : 4'hF;
            exp_d = {mdl[4*k+3], mdl[4*k+2], mdl[4*k+1], mdl[4*k]};
            msk = {{8{exp_k[3]}}, {8{exp_k[2]}}, {8{exp_k[1]}}, {8{exp_k[0]}}};
            checks++;
            if ((tdata & msk) !== (exp_d & msk) || tkeep !== exp_k || tlast !== (k == nb - 1)) begin
               errors++;
               $display("FAIL beat size=%0d k=%0d: got d=%h keep=%h last=%b, want d=%h keep=%h last=%b",
                        sz, k, tdata & msk, tkeep, tlast, exp_d & msk, exp_k, (k == nb - 1));
            end
            k++;
            done = tlast;
         end
         pstall = tvalid && !tready;
         pd = tdata;
         pk = tkeep;
         pl = tlast;
         step;
         cyc++;
      end
      send = 1'b0;
      wvalid = 1'b0;
      wsize_valid = 1'b0;
      tready = 1'b0;
      if (done) exp_count++;
      checks++;
      if (k != nb) begin
         errors++;
         $display("FAIL beat_count size=%0d: got %0d, want %0d", sz, k, nb);
      end
      checks++;
      if (send_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL send_count: got %0d, want %0d", send_count, exp_count);
      end
      checks++;
      if (req !== 1'b1 || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL back_to_idle: req=%b tvalid=%b, want 1/0", req, tvalid);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (req !== 1'b1 || tvalid !== 1'b0 || tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req=%b tvalid=%b tlast=%b, want 1/0/0", req, tvalid, tlast);
      end
      checks++;
      if (tdata !== 32'h0 || tkeep !== 4'h0 || tuser !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: tdata=%h tkeep=%h tuser=%b, want 0/0/0", tdata, tkeep, tuser);
      end
      checks++;
      if (send_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_count: got %0d, want 0", send_count);
      end
   endtask

   task automatic test_basic;
      for (int w = 0; w < 16; w++)
         wr(4 * w, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 2);
      set_size(64);
      run_frame(64, 100, 1'b0);
   endtask

   task automatic test_partial_last;
      set_size(61);
      run_frame(61, 100, 1'b0);
   endtask

   task automatic test_mixed_writes;
      wr(5, 32'hAA, 0);
      wr(6, 32'hBBCC, 1);
      set_size(8);
      run_frame(8, 100, 1'b0);
   endtask

   task automatic test_random_stall;
      for (int w = 0; w < 375; w++) wr(4 * w, $urandom, 2);
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(1) == 0) wr($urandom_range(1499), $urandom, 0);
         else wr(2 * $urandom_range(749), $urandom, 1);
      end
      set_size(1500);
      run_frame(1500, 50, 1'b0);
   endtask

   task automatic test_invalid_size;
      int sizes [2] = '{0, 2049};
      for (int s = 0; s < 2; s++) begin
         bit seen = 1'b0;
         set_size(sizes[s]);
         send = 1'b1;
         step;
         send = 1'b0;
         for (int c = 0; c < 6; c++) begin
            seen |= (tvalid !== 1'b0) || (req !== 1'b1);
            step;
         end
         checks++;
         if (seen || send_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL invalid_size=%0d: activity=%b count=%0d, want 0/%0d", sizes[s], seen, send_count, exp_count);
         end
      end
   endtask

   task automatic test_busy_ignored;
      set_size(64);
      run_frame(64, 70, 1'b1);
      run_frame(64, 100, 1'b0);
      for (int c = 0; c < 5; c++) step;
      checks++;
      if (send_count !== 16'(exp_count) || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL busy_extra_send: count=%0d tvalid=%b, want %0d/0", send_count, tvalid, exp_count);
      end
   endtask

   task automatic test_simultaneous;
      set_size(64);
      wsize_valid = 1'b1;
      wsize = 12'd8;
      wvalid = 1'b1;
      waddr = 11'd0;
      wdata = 32'h77;
      wsize_l = 2'd0;
      mdl[0] = 8'h77;
      run_frame(64, 100, 1'b0);
      run_frame(8, 100, 1'b0);
   endtask

   task automatic test_reset_mid_frame;
      int lat = 0;
      logic [31:0] exp_d;
      set_size(64);
      send = 1'b1;
      step;
      send = 1'b0;
      while (!tvalid && lat < 10) begin
         step;
         lat++;
      end
      tready = 1'b1;
      for (int i = 0; i < 7; i++) step;
      exp_d = {mdl[31], mdl[30], mdl[29], mdl[28]};
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_d) begin
         errors++;
         $display("FAIL beat7_before_reset: tvalid=%b tdata=%h, want 1/%h", tvalid, tdata, exp_d);
      end
      rst = 1'b1;
      step;
      rst = 1'b0;
      tready = 1'b0;
      exp_count = 0;
      checks++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || send_count !== 16'h0 || req !== 1'b1) begin
         errors++;
         $display("FAIL mid_frame_reset: tvalid=%b tlast=%b count=%0d req=%b, want 0/0/0/1", tvalid, tlast, send_count, req);
      end
      for (int w = 0; w < 16; w++) wr(4 * w, $urandom, 2);
      set_size(64);
      run_frame(64, 100, 1'b0);
   endtask

   initial begin
      step;
      step;
      step;
      rst = 1'b0;
      test_reset;
      test_basic;
      test_partial_last;
      test_mixed_writes;
      test_random_stall;
      test_invalid_size;
      test_busy_ignored;
      test_simultaneous;
      test_reset_mid_frame;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ethernet_tx_packet_streamer.md
Name: ethernet_tx_packet_streamer

Overview:
- Transmit-side packet buffer between the Ethernet control unit (MMIO side) and the RGMII MAC TX AXI-Stream input.
- Software writes one frame (up to eth_mtu_p bytes) into an internal byte-addressable buffer, programs its length, then issues send.
- The block streams the frame to the MAC as AXIS beats with correct tkeep/tlast, then re-arms for the next frame.
- Single clock domain (the logic clock); the MAC's async FIFO handles the clock crossing.

Parameters:
- data_width_p, 32, AXIS and write-data width in bits; one of 32 or 64.
- eth_mtu_p, 2048, buffer capacity in bytes; power of two.
- Derived, not overridable: B = data_width_p/8; size_width_lp = clog2(eth_mtu_p+1); addr_width_lp = clog2(eth_mtu_p); wsize_width_lp = `BSG_WIDTH(clog2(B)).

Ports:
- clk_i, in, 1, logic clock.
- reset_i, in, 1, synchronous active-high reset.
- packet_send_i, in, 1, one-cycle pulse: transmit buffered frame.
- packet_req_o, out, 1, 1 = idle; accepting writes, size updates and send.
- packet_wsize_valid_i, in, 1, latch packet_wsize_i.
- packet_wsize_i, in, size_width_lp, frame length in bytes.
- packet_wvalid_i, in, 1, buffer write strobe.
- packet_waddr_i, in, addr_width_lp, byte address of write.
- packet_wdata_i, in, data_width_p, write data, right-justified.
- packet_wdata_size_i, in, wsize_width_lp, log2 of write bytes (0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B).
- tx_axis_tdata_o, out, data_width_p, stream data; byte 0 is the lowest buffer address.
- tx_axis_tkeep_o, out, B, valid byte lanes.
- tx_axis_tvalid_o, out, 1, beat valid.
- tx_axis_tlast_o, out, 1, last beat of frame.
- tx_axis_tready_i, in, 1, MAC ready.
- tx_axis_tuser_o, out, 1, frame error flag; constant 0.
- send_count_o, out, 16, completed frames; wraps at 2^16.

Behaviour:
- Reset: IDLE state; packet_req_o=1, tx_axis_tvalid_o=0, tlast=0, tkeep=0, tdata=0, size register=0, send_count_o=0. Buffer contents are undefined after reset.
- States:
  - IDLE: packet_req_o=1.
  - FILL: prefetch, packet_req_o=0.
  - STREAM: packet_req_o=0.
  - Reset taken mid-frame aborts immediately. tvalid drops the next cycle and no tlast is sent; the MAC FIFO discards the partial frame.
- Buffer writes (IDLE only; ignored otherwise):
  - Write bytes [waddr, waddr + 2^wdata_size - 1] with the low bytes of wdata, placed at lane waddr mod B; other bytes are unchanged.
  - waddr must be aligned to the write size. A misaligned write is dropped, and an assertion fires in simulation.
- Size register: packet_wsize_valid_i in IDLE latches packet_wsize_i. It is ignored when not in IDLE.
- Send acceptance:
  - packet_send_i in IDLE with 1 <= size <= eth_mtu_p → FILL.
  - packet_send_i with size 0 or > eth_mtu_p is ignored; stay IDLE.
  - packet_send_i is ignored outside IDLE.
- Simultaneous events in IDLE:
  - Send + size update in the same cycle: the send uses the previously latched size; the new size is stored for the next frame.
  - Send + buffer write in the same cycle: the write is committed and is visible in the transmitted frame.
- FILL: issue sync reads of word 0 (and word 1 if present) into a 2-entry read-ahead. First tvalid asserts exactly 2 cycles after the accepted send cycle.
- STREAM:
  - beats = ceil(size/B); beat k carries buffer word k.
  - tkeep is all-ones except on the last beat, where tkeep = (1 << r) - 1 with r = size - (beats-1)*B (r in 1..B).
  - tlast=1 only on the last beat.
- AXIS rules:
  - tdata/tkeep/tlast must be stable while tvalid=1 and tready=0.
  - With tready held high, beats issue one per cycle with no bubbles.
  - tready may toggle arbitrarily without loss or duplication.
- Frame completion: on the last-beat handshake, in the same cycle, send_count_o increments. Next cycle: IDLE, packet_req_o=1, tvalid=0.
- Size register and buffer contents persist after a send, so resending the same frame needs only packet_send_i.

Test Plan:
- Reset, write bytes 0..63 = 0x00..0x3F with 4B writes, size=64, send, tready=1 → 16 beats, one per cycle; first tvalid 2 cycles after send; beat0 tdata=0x03020100; tlast on beat 15; tkeep=0xF throughout; send_count_o=1; packet_req_o=1 the next cycle.
- size=61, same data → 16 beats; last tkeep=0x1; tdata byte0=0x3C.
- Mixed 1B/2B writes (byte 5=0xAA, halfword at 6=0xBBCC), size=8 → beat1 tdata=0xBBCCAA04; tkeep=0xF.
- tready pseudo-random 50% during a 1500-byte frame → 375 beats exactly, in order, outputs stable while stalled, one tlast.
- Send with size=0, then size=2049, then send pulses and writes during STREAM → no tvalid for the invalid sizes; busy-time writes and sends have no effect on the frame in flight; send_count_o increments only once.
- reset_i asserted at beat 7 of a 64-byte frame → tvalid=0 the next cycle; send_count_o=0; packet_req_o=1; a new frame sends correctly afterwards.
